// File: rtl/waveform_generator.sv
// waveform_generator: DDS sample source (sine/square/saw/triangle).
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   wave_def - 00 sine, 01 square, 10 sawtooth, 11 triangle
//   freq     - output frequency in Hz
//   amp      - amplitude scale, (amp+1)/1024
//   signal   - registered unsigned 10-bit sample
module waveform_generator #(
    parameter int unsigned CLK_HZ   = 10000000,
    parameter int unsigned PHASE_W  = 32,
    parameter int unsigned INC_MULT = 109951
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] wave_def,
    input  logic [15:0] freq,
    input  logic [9:0] amp,
    output logic [9:0] signal
);

    // INC_MULT must track round(2^(PHASE_W+8)/CLK_HZ).
    localparam longint unsigned INC_EXPECT =
        ((64'd1 << (PHASE_W + 8)) + 64'(CLK_HZ / 2)) / 64'(CLK_HZ);

    if (INC_EXPECT != 64'(INC_MULT)) begin : g_bad_mult
        $error("INC_MULT does not match CLK_HZ/PHASE_W");
    end

    localparam int MULT_W = $clog2(INC_MULT + 1);
    localparam int PROD_W = 16 + MULT_W;

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;
    logic [9:0]         signal_q;
    logic [9:0]         signal_d;

    logic [PROD_W-1:0]  inc_prod;
    logic [PHASE_W-1:0] inc;
    logic [9:0]         p;
    logic [1:0]         quad;
    logic [5:0]         k_idx;
    logic [8:0]         q_val;
    logic [9:0]         raw;
    logic [20:0]        scale_prod;

    // Quarter-wave table: round(511*sin((k+0.5)*pi/128)).
    function automatic logic [8:0] sin_q(input logic [5:0] idx);
        logic [8:0] v;
        v = 9'd0;
        unique case (idx)
            6'd0:  v = 9'd6;
            6'd1:  v = 9'd19;
            6'd2:  v = 9'd31;
            6'd3:  v = 9'd44;
            6'd4:  v = 9'd56;
            6'd5:  v = 9'd69;
            6'd6:  v = 9'd81;
            6'd7:  v = 9'd94;
            6'd8:  v = 9'd106;
            6'd9:  v = 9'd118;
            6'd10: v = 9'd130;
            6'd11: v = 9'd142;
            6'd12: v = 9'd154;
            6'd13: v = 9'd166;
            6'd14: v = 9'd178;
            6'd15: v = 9'd190;
            6'd16: v = 9'd201;
            6'd17: v = 9'd213;
            6'd18: v = 9'd224;
            6'd19: v = 9'd235;
            6'd20: v = 9'd246;
            6'd21: v = 9'd257;
            6'd22: v = 9'd268;
            6'd23: v = 9'd279;
            6'd24: v = 9'd289;
            6'd25: v = 9'd299;
            6'd26: v = 9'd309;
            6'd27: v = 9'd319;
            6'd28: v = 9'd329;
            6'd29: v = 9'd338;
            6'd30: v = 9'd348;
            6'd31: v = 9'd357;
            6'd32: v = 9'd366;
            6'd33: v = 9'd374;
            6'd34: v = 9'd383;
            6'd35: v = 9'd391;
            6'd36: v = 9'd399;
            6'd37: v = 9'd407;
            6'd38: v = 9'd414;
            6'd39: v = 9'd421;
            6'd40: v = 9'd428;
            6'd41: v = 9'd435;
            6'd42: v = 9'd441;
            6'd43: v = 9'd448;
            6'd44: v = 9'd454;
            6'd45: v = 9'd459;
            6'd46: v = 9'd465;
            6'd47: v = 9'd470;
            6'd48: v = 9'd474;
            6'd49: v = 9'd479;
            6'd50: v = 9'd483;
            6'd51: v = 9'd487;
            6'd52: v = 9'd491;
            6'd53: v = 9'd494;
            6'd54: v = 9'd497;
            6'd55: v = 9'd500;
            6'd56: v = 9'd502;
            6'd57: v = 9'd505;
            6'd58: v = 9'd506;
            6'd59: v = 9'd508;
            6'd60: v = 9'd509;
            6'd61: v = 9'd510;
            6'd62: v = 9'd511;
            6'd63: v = 9'd511;
        endcase
        return v;
    endfunction

    // Hz -> phase step: freq * 2^(PHASE_W+8)/CLK_HZ, then drop 8 bits.
    always_comb begin
        inc_prod = PROD_W'(freq) * PROD_W'(INC_MULT);
        inc      = PHASE_W'(inc_prod >> 8);
        phase_d  = phase_q + inc;
    end

    always_comb begin
        p     = phase_q[PHASE_W-1 -: 10];
        quad  = p[9:8];
        // Odd quadrants read the table mirrored (63-k == ~k).
        k_idx = quad[0] ? ~p[7:2] : p[7:2];
        q_val = sin_q(k_idx);
        raw   = 10'd0;
        unique case (wave_def)
            2'b00: begin
                if (quad[1]) begin
                    raw = 10'd511 - {1'b0, q_val};
                end else begin
                    raw = 10'd512 + {1'b0, q_val};
                end
            end
            2'b01: raw = p[9] ? 10'd0 : 10'd1023;
            2'b10: raw = p;
            2'b11: begin
                if (p[9]) begin
                    raw = 10'(11'd2047 - {p, 1'b0});
                end else begin
                    raw = {p[8:0], 1'b0};
                end
            end
        endcase
        // raw <= 1023 and amp+1 <= 1024, so the shifted result fits 10 bits.
        scale_prod = 21'(raw) * 21'({1'b0, amp} + 11'd1);
        signal_d   = 10'(scale_prod >> 10);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= '0;
            signal_q <= '0;
        end else begin
            phase_q  <= phase_d;
            signal_q <= signal_d;
        end
    end

    assign signal = signal_q;

endmodule

// File: tb/tb_waveform_generator.sv
// tb_waveform_generator: directed + random checks of waveform_generator
// against an arithmetic phase/sample model.
module tb_waveform_generator;

    localparam int unsigned INC_MULT = 109951;
    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  wave_def = 2'd0;
    logic [15:0] freq = 16'd0;
    logic [9:0]  amp = 10'd0;
    logic [9:0]  signal;

    int total = 0;
    int bad = 0;
    longint unsigned m_phase = 0;
    int q_tab[64];
    int obs = 0;

    waveform_generator #(
        .CLK_HZ(10000000),
        .PHASE_W(32),
        .INC_MULT(INC_MULT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wave_def(wave_def),
        .freq(freq),
        .amp(amp),
        .signal(signal)
    );

    always #50 clk = ~clk;

    function automatic longint unsigned inc_of(input logic [15:0] f);
        return (longint'(f) * longint'(INC_MULT)) >> 8;
    endfunction

    function automatic int raw_of(input int wave, input int p);
        int quad;
        int k;
        quad = p / 256;
        k = (p % 256) / 4;
        case (wave)
            0: begin
                case (quad)
                    0: return 512 + q_tab[k];
                    1: return 512 + q_tab[63 - k];
                    2: return 511 - q_tab[k];
                    default: return 511 - q_tab[63 - k];
                endcase
            end
            1: return (p < 512) ? 1023 : 0;
            2: return p;
            default: return (p < 512) ? 2 * p : 2047 - 2 * p;
        endcase
    endfunction

    function automatic int sample_of(input int wave, input int p, input int a);
        return raw_of(wave, p) * (a + 1) / 1024;
    endfunction

    task automatic check(input string tag, input logic [31:0] o,
                         input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // One clock: model the edge, then compare on the falling edge.
    task automatic tick(input string tag);
        int e;
        @(posedge clk);
        if (rst) begin
            e = 0;
        end else begin
            e = sample_of(int'(wave_def), int'(m_phase >> 22), int'(amp));
            m_phase = (m_phase + inc_of(freq)) & 64'hFFFF_FFFF;
        end
        @(negedge clk);
        obs = int'(signal);
        check(tag, {22'd0, signal}, 32'(e));
    endtask

    initial begin
        int hi;
        int other;
        int prev;
        int step;
        int bad_step;
        int wraps;
        int mx;
        int mn;
        int changes;
        int held;
        int n;

        for (int k = 0; k < 64; k++) begin
            q_tab[k] = $rtoi(511.0 * $sin((k + 0.5) * PI / 128.0) + 0.5);
        end

        @(negedge clk);
        check("reset_signal", {22'd0, signal}, 32'd0);
        rst = 1'b0;
        m_phase = 0;

        // Square 20 kHz, amp 256.
        wave_def = 2'b01;
        freq = 16'd20000;
        amp = 10'd256;
        tick("sq20k");
        check("sq20k_first", 32'(obs), 32'd256);
        hi = 1;
        other = 0;
        for (int i = 0; i < 999; i++) begin
            tick("sq20k");
            if (obs == 256) hi++;
            else if (obs != 0) other++;
        end
        check("sq20k_levels", 32'(other), 32'd0);
        check("sq20k_duty", 32'(hi >= 498 && hi <= 502), 32'd1);

        // Square 10 kHz, full scale.
        freq = 16'd10000;
        amp = 10'd1023;
        other = 0;
        hi = 0;
        for (int i = 0; i < 1500; i++) begin
            tick("sq10k");
            if (obs == 1023) hi++;
            else if (obs != 0) other++;
        end
        check("sq10k_levels", 32'(other), 32'd0);
        check("sq10k_hi_seen", 32'(hi > 400), 32'd1);

        // Sawtooth 10 kHz.
        wave_def = 2'b10;
        tick("saw");
        prev = obs;
        bad_step = 0;
        wraps = 0;
        for (int i = 0; i < 1200; i++) begin
            tick("saw");
            step = obs - prev;
            if (prev > 900 && obs < 100) wraps++;
            else if (step != 1 && step != 2) bad_step++;
            prev = obs;
        end
        check("saw_step", 32'(bad_step), 32'd0);
        check("saw_wrap", 32'(wraps >= 1), 32'd1);

        // Triangle 10 kHz, amp 511.
        wave_def = 2'b11;
        amp = 10'd511;
        mx = 0;
        mn = 1023;
        for (int i = 0; i < 1100; i++) begin
            tick("tri");
            if (obs > mx) mx = obs;
            if (obs < mn) mn = obs;
        end
        check("tri_max", 32'(mx), 32'd511);
        check("tri_min", 32'(mn), 32'd0);

        // Sine 20 kHz full scale, then amp 0.
        wave_def = 2'b00;
        freq = 16'd20000;
        amp = 10'd1023;
        mx = 0;
        mn = 1023;
        for (int i = 0; i < 600; i++) begin
            tick("sine");
            if (obs > mx) mx = obs;
            if (obs < mn) mn = obs;
        end
        check("sine_max", 32'(mx), 32'd1023);
        check("sine_min", 32'(mn), 32'(511 - q_tab[63]));
        amp = 10'd0;
        other = 0;
        for (int i = 0; i < 200; i++) begin
            tick("sine_amp0");
            if (obs != 0) other++;
        end
        check("sine_amp0_zero", 32'(other), 32'd0);

        // Freeze with freq 0, then async reset mid-ramp.
        wave_def = 2'b10;
        freq = 16'd10000;
        amp = 10'd1023;
        for (int i = 0; i < 300; i++) tick("saw2");
        freq = 16'd0;
        tick("freeze_first");
        held = obs;
        changes = 0;
        for (int i = 0; i < 100; i++) begin
            tick("freeze");
            if (obs != held) changes++;
        end
        check("freeze_const", 32'(changes), 32'd0);
        freq = 16'd10000;
        for (int i = 0; i < 200; i++) tick("saw3");
        #10;
        rst = 1'b1;
        #1;
        check("rst_async", {22'd0, signal}, 32'd0);
        m_phase = 0;
        for (int i = 0; i < 3; i++) tick("rst_hold");
        rst = 1'b0;
        tick("restart");
        check("restart_p0", 32'(obs), 32'd0);
        for (int i = 0; i < 300; i++) tick("restart_run");

        // Random segments.
        for (int s = 0; s < 20; s++) begin
            wave_def = 2'($urandom_range(0, 3));
            freq = 16'($urandom_range(0, 65535));
            amp = 10'($urandom_range(0, 1023));
            n = int'($urandom_range(20, 200));
            for (int i = 0; i < n; i++) tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
